// File: rtl/regfile_wb_sequencer_pkg.sv
// Shared encodings for the register-file writeback sequencer.
// Holds the beat FSM state encoding, the PC register index and the grant encoding.
// Pure declarations; no logic.
package regfile_wb_sequencer_pkg;

   // Register index that aliases the program counter; never stored in the file.
   localparam int unsigned PC_ADDR = 15;

   // Beat sequencer states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_LO = 2'd1,
      WR_HI = 2'd2
   } state_e;

   // Identity of the requester that won the most recent handshake.
   typedef enum logic {
      GRANT_A = 1'b0,
      GRANT_B = 1'b1
   } grant_e;

endpackage : regfile_wb_sequencer_pkg

// File: rtl/regfile_wb_sequencer_rr_arb2.sv
// Two-requester round-robin arbiter for the register-file write slot.
// Zero-cycle: readies are combinational from free_i, the valids and last grant.
// Both readies are 0 while free_i is low; a tie goes to the requester that did not win last.
module rr_arb2
   import regfile_wb_sequencer_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic free_i,
   input  logic a_vld_i,
   input  logic b_vld_i,
   output logic a_rdy_o,
   output logic b_rdy_o
);

   grant_e last_grant_q;
   grant_e last_grant_d;

   // Ready selection: single requester wins outright, ties and the idle
   // case both point at the requester that was not granted last.
   always_comb begin
      a_rdy_o = 1'b0;
      b_rdy_o = 1'b0;
      if (free_i) begin
         if (a_vld_i && !b_vld_i) begin
            a_rdy_o = 1'b1;
         end else if (b_vld_i && !a_vld_i) begin
            b_rdy_o = 1'b1;
         end else begin
            a_rdy_o = (last_grant_q == GRANT_B);
            b_rdy_o = (last_grant_q == GRANT_A);
         end
      end
   end

   // Next grant history: only an actual handshake moves it.
   always_comb begin
      last_grant_d = last_grant_q;
      if (a_vld_i && a_rdy_o) begin
         last_grant_d = GRANT_A;
      end else if (b_vld_i && b_rdy_o) begin
         last_grant_d = GRANT_B;
      end
   end

   // Grant history register; reset to B so that A wins the first tie.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_grant_q <= GRANT_B;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule : rr_arb2

// File: rtl/regfile_wb_sequencer.sv
// Shares the single register-file write port between the main FSM (A) and the multiplier (B).
// Latency: handshake in cycle N writes on the edge ending cycle N+1; 64-bit results take two beats.
// Backpressure: both readies drop during the low beat of a 64-bit result and while reset_n is low.
module regfile_wb_sequencer #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned PC_ADDR = regfile_wb_sequencer_pkg::PC_ADDR
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_rd,
   input  logic [DATA_W-1:0] a_wd,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic              b_long,
   input  logic [ADDR_W-1:0] b_rd_lo,
   input  logic [ADDR_W-1:0] b_rd_hi,
   input  logic [DATA_W-1:0] b_lo,
   input  logic [DATA_W-1:0] b_hi,
   output logic              we3,
   output logic              Src_64b,
   output logic [ADDR_W-1:0] wa3_32,
   output logic [DATA_W-1:0] wd3_32,
   output logic [ADDR_W-1:0] wa3_64,
   output logic [DATA_W-1:0] wd3_64,
   output logic              pc_we,
   output logic [DATA_W-1:0] pc_wd,
   output logic              busy
);

   import regfile_wb_sequencer_pkg::*;

   localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(PC_ADDR);

   state_e            state_q, state_d;
   logic              cur_long_q, cur_long_d;
   logic [ADDR_W-1:0] rd_lo_q, rd_lo_d;
   logic [ADDR_W-1:0] rd_hi_q, rd_hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic [DATA_W-1:0] hi_q, hi_d;

   logic              free;
   logic              a_hs;
   logic              b_hs;
   logic              beat_act;
   logic [ADDR_W-1:0] beat_addr;
   logic [DATA_W-1:0] beat_data;

   // Slot is open unless the low beat of a 64-bit result is on the port;
   // holding it closed during reset keeps every output quiet.
   always_comb begin
      free = reset_n &&
             ((state_q == IDLE) ||
              (state_q == WR_LO && !cur_long_q) ||
              (state_q == WR_HI));
   end

   rr_arb2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .free_i  (free),
      .a_vld_i (a_valid),
      .b_vld_i (b_valid),
      .a_rdy_o (a_ready),
      .b_rdy_o (b_ready)
   );

   assign a_hs = a_valid && a_ready;
   assign b_hs = b_valid && b_ready;

   // Next-state and capture: a pending high beat always goes next,
   // otherwise a handshake loads a new request and anything else idles.
   always_comb begin
      state_d    = state_q;
      cur_long_d = cur_long_q;
      rd_lo_d    = rd_lo_q;
      rd_hi_d    = rd_hi_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      if (state_q == WR_LO && cur_long_q) begin
         state_d = WR_HI;
      end else if (a_hs) begin
         state_d    = WR_LO;
         cur_long_d = 1'b0;
         rd_lo_d    = a_rd;
         lo_d       = a_wd;
      end else if (b_hs) begin
         state_d    = WR_LO;
         cur_long_d = b_long;
         rd_lo_d    = b_rd_lo;
         lo_d       = b_lo;
         if (b_long) begin
            rd_hi_d = b_rd_hi;
            hi_d    = b_hi;
         end
      end else begin
         state_d = IDLE;
      end
   end

   // State and capture registers; reset drops any pending beat.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cur_long_q <= 1'b0;
         rd_lo_q    <= '0;
         rd_hi_q    <= '0;
         lo_q       <= '0;
         hi_q       <= '0;
      end else begin
         state_q    <= state_d;
         cur_long_q <= cur_long_d;
         rd_lo_q    <= rd_lo_d;
         rd_hi_q    <= rd_hi_d;
         lo_q       <= lo_d;
         hi_q       <= hi_d;
      end
   end

   // Beat decode: pick the active beat's address/data and steer PC writes
   // to the strobe instead of the register file.
   always_comb begin
      beat_act  = 1'b0;
      beat_addr = rd_lo_q;
      beat_data = lo_q;
      Src_64b   = 1'b0;
      case (state_q)
         WR_LO: begin
            beat_act = 1'b1;
         end
         WR_HI: begin
            beat_act  = 1'b1;
            beat_addr = rd_hi_q;
            beat_data = hi_q;
            Src_64b   = 1'b1;
         end
         default: begin
            beat_act = 1'b0;
         end
      endcase
      we3   = beat_act && (beat_addr != PC_IDX);
      pc_we = beat_act && (beat_addr == PC_IDX);
      pc_wd = beat_data;
      busy  = (state_q != IDLE);
   end

   assign wa3_32 = rd_lo_q;
   assign wd3_32 = lo_q;
   assign wa3_64 = rd_hi_q;
   assign wd3_64 = hi_q;

endmodule : regfile_wb_sequencer
